// File: rtl/run_dump_ctrl.sv
// run_dump_ctrl
//
// Run controller and memory-dump engine for the multi-cycle processor test
// harness. Holds the core in reset, runs it until a halt instruction or a
// cycle timeout, then freezes the core, takes over the DMEM address bus and
// streams a window of DMEM words out over a valid/ready port.
//
// Configuration macro:
//   RUN_DUMP_INITIAL_EN  when defined, a full dump (dump_phase=0) is taken
//                        after the reset hold and before the core runs.
//                        When undefined, RESET_HOLD goes straight to RUN and
//                        dump_phase is tied to 1.
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   asynchronous, active-high
//   start          in   begin a run (sampled only in IDLE and DONE)
//   inst_from_mem  in   currently fetched instruction
//   proc_reset     out  reset to the processor
//   mem_sel        out  1 = controller owns the DMEM address bus
//   dmem_addr      out  dump read address
//   dmem_data      in   DMEM read data, combinational from dmem_addr
//   dump_valid     out  dump stream valid
//   dump_ready     in   dump stream ready
//   dump_data      out  dumped word
//   dump_index     out  word index within the dump window
//   dump_last      out  final word of the dump window
//   dump_phase     out  0 = initial dump, 1 = final dump
//   cycle_count    out  RUN cycles elapsed
//   done           out  run and final dump complete
//   timed_out      out  run ended on the cycle timeout

module run_dump_ctrl #(
    parameter int unsigned        ADDR_W       = 32,
    parameter int unsigned        DATA_W       = 32,
    parameter int unsigned        INSTR_W      = 32,
    parameter int unsigned        DUMP_BASE    = 8192,
    parameter int unsigned        DUMP_WORDS   = 46,
    parameter int unsigned        RESET_CYCLES = 1,
    parameter int unsigned        MAX_CYCLES   = 100000,
    parameter logic [INSTR_W-1:0] HALT_INSTR   = 32'hFFFF_FFFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] inst_from_mem,
    output logic               proc_reset,
    output logic               mem_sel,
    output logic [ADDR_W-1:0]  dmem_addr,
    input  logic [DATA_W-1:0]  dmem_data,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [DATA_W-1:0]  dump_data,
    output logic [15:0]        dump_index,
    output logic               dump_last,
    output logic               dump_phase,
    output logic [31:0]        cycle_count,
    output logic               done,
    output logic               timed_out
);

    localparam logic [31:0] HOLD_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] RUN_LAST  = 32'(MAX_CYCLES - 1);
    localparam logic [15:0] IDX_LAST  = 16'(DUMP_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle        = 3'd0,
        StResetHold   = 3'd1,
`ifdef RUN_DUMP_INITIAL_EN
        StInitDumpRd  = 3'd2,
        StInitDumpOut = 3'd3,
`endif
        StRun         = 3'd4,
        StDumpRd      = 3'd5,
        StDumpOut     = 3'd6,
        StDone        = 3'd7
    } state_e;

    state_e              r_state;
    logic [31:0]         r_hold;
    logic [15:0]         r_idx;
    logic [DATA_W-1:0]   r_dump_data;
    logic [31:0]         r_cycle;
    logic                r_timed_out;

    state_e              w_state_nxt;
    logic [31:0]         w_hold_nxt;
    logic [15:0]         w_idx_nxt;
    logic [DATA_W-1:0]   w_dump_data_nxt;
    logic [31:0]         w_cycle_nxt;
    logic                w_timed_out_nxt;

    logic                w_proc_reset;
    logic                w_mem_sel;
    logic                w_dump_valid;
    logic [ADDR_W-1:0]   w_dmem_addr;
    logic [ADDR_W-1:0]   w_dump_addr;
    logic                w_idx_last;

`ifdef RUN_DUMP_INITIAL_EN
    logic                r_phase;
    logic                w_phase_nxt;
`endif

    // Word address wraps modulo 2^ADDR_W by construction of the sum width.
    assign w_dump_addr = ADDR_W'(DUMP_BASE) + (ADDR_W'(r_idx) << 2);
    assign w_idx_last  = (r_idx == IDX_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_hold      <= '0;
            r_idx       <= '0;
            r_dump_data <= '0;
            r_cycle     <= '0;
            r_timed_out <= 1'b0;
`ifdef RUN_DUMP_INITIAL_EN
            r_phase     <= 1'b1;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_idx       <= w_idx_nxt;
            r_dump_data <= w_dump_data_nxt;
            r_cycle     <= w_cycle_nxt;
            r_timed_out <= w_timed_out_nxt;
`ifdef RUN_DUMP_INITIAL_EN
            r_phase     <= w_phase_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold;
        w_idx_nxt       = r_idx;
        w_dump_data_nxt = r_dump_data;
        w_cycle_nxt     = r_cycle;
        w_timed_out_nxt = r_timed_out;
`ifdef RUN_DUMP_INITIAL_EN
        w_phase_nxt     = r_phase;
`endif
        w_proc_reset    = 1'b1;
        w_mem_sel       = 1'b0;
        w_dump_valid    = 1'b0;
        w_dmem_addr     = '0;

        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_nxt     = StResetHold;
                    w_hold_nxt      = '0;
                    w_idx_nxt       = '0;
                    w_cycle_nxt     = '0;
                    w_timed_out_nxt = 1'b0;
                end
            end

            StResetHold: begin
                if (r_hold == HOLD_LAST) begin
`ifdef RUN_DUMP_INITIAL_EN
                    w_state_nxt = StInitDumpRd;
                    w_phase_nxt = 1'b0;
                    w_idx_nxt   = '0;
`else
                    w_state_nxt = StRun;
`endif
                end else begin
                    w_hold_nxt = r_hold + 32'd1;
                end
            end

`ifdef RUN_DUMP_INITIAL_EN
            StInitDumpRd: begin
                w_mem_sel       = 1'b1;
                w_dmem_addr     = w_dump_addr;
                w_dump_data_nxt = dmem_data;
                w_state_nxt     = StInitDumpOut;
            end

            StInitDumpOut: begin
                w_mem_sel    = 1'b1;
                w_dmem_addr  = w_dump_addr;
                w_dump_valid = 1'b1;
                if (dump_ready) begin
                    if (w_idx_last) begin
                        // Final dump restarts from word 0 with phase 1.
                        w_state_nxt = StRun;
                        w_phase_nxt = 1'b1;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = StInitDumpRd;
                        w_idx_nxt   = r_idx + 16'd1;
                    end
                end
            end
`endif

            StRun: begin
                w_proc_reset = 1'b0;
                // Halt has priority over timeout; the exit cycle is not counted
                // so cycle_count holds the value seen on the deciding cycle.
                if (inst_from_mem == HALT_INSTR) begin
                    w_state_nxt = StDumpRd;
                end else if (r_cycle == RUN_LAST) begin
                    w_state_nxt     = StDumpRd;
                    w_timed_out_nxt = 1'b1;
                end else if (r_cycle != '1) begin
                    w_cycle_nxt = r_cycle + 32'd1;
                end
            end

            StDumpRd: begin
                w_mem_sel       = 1'b1;
                w_dmem_addr     = w_dump_addr;
                w_dump_data_nxt = dmem_data;
                w_state_nxt     = StDumpOut;
            end

            StDumpOut: begin
                w_mem_sel    = 1'b1;
                w_dmem_addr  = w_dump_addr;
                w_dump_valid = 1'b1;
                if (dump_ready) begin
                    if (w_idx_last) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_state_nxt = StDumpRd;
                        w_idx_nxt   = r_idx + 16'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign proc_reset  = w_proc_reset;
    assign mem_sel     = w_mem_sel;
    assign dmem_addr   = w_dmem_addr;
    assign dump_valid  = w_dump_valid;
    assign dump_data   = r_dump_data;
    assign dump_index  = r_idx;
    assign dump_last   = w_dump_valid && w_idx_last;
    assign cycle_count = r_cycle;
    assign done        = (r_state == StDone);
    assign timed_out   = r_timed_out;

`ifdef RUN_DUMP_INITIAL_EN
    assign dump_phase  = r_phase;
`else
    assign dump_phase  = 1'b1;
`endif

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Self-checking bench for run_dump_ctrl with a small dump window and a short
// timeout. A DMEM array answers the controller's read address; expected beats,
// cycle counts and timeout flags come from the run/dump rules directly.

module tb_run_dump_ctrl;

    localparam int unsigned RC   = 3;
    localparam int unsigned DW   = 4;
    localparam int unsigned MC   = 20;
    localparam int unsigned BASE = 8192;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] inst_from_mem;
    logic        proc_reset;
    logic        mem_sel;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [15:0] dump_index;
    logic        dump_last;
    logic        dump_phase;
    logic [31:0] cycle_count;
    logic        done;
    logic        timed_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [DW];
    logic [31:0] w_off;

    run_dump_ctrl #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .INSTR_W      (32),
        .DUMP_BASE    (BASE),
        .DUMP_WORDS   (DW),
        .RESET_CYCLES (RC),
        .MAX_CYCLES   (MC),
        .HALT_INSTR   (HALT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .inst_from_mem (inst_from_mem),
        .proc_reset    (proc_reset),
        .mem_sel       (mem_sel),
        .dmem_addr     (dmem_addr),
        .dmem_data     (dmem_data),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_data     (dump_data),
        .dump_index    (dump_index),
        .dump_last     (dump_last),
        .dump_phase    (dump_phase),
        .cycle_count   (cycle_count),
        .done          (done),
        .timed_out     (timed_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // DMEM: combinational read of the window; anything else reads a marker.
    always_comb begin
        w_off     = dmem_addr - BASE;
        dmem_data = 32'hDEAD_BEEF;
        if (w_off[1:0] == 2'b00 && (w_off >> 2) < DW) dmem_data = mem[w_off[3:2]];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_proc_reset"}, 32'(proc_reset), 1);
        chk({tag, "_mem_sel"},    32'(mem_sel), 0);
        chk({tag, "_dmem_addr"},  dmem_addr, 0);
        chk({tag, "_valid"},      32'(dump_valid), 0);
        chk({tag, "_data"},       dump_data, 0);
        chk({tag, "_index"},      32'(dump_index), 0);
        chk({tag, "_last"},       32'(dump_last), 0);
        chk({tag, "_phase"},      32'(dump_phase), 1);
        chk({tag, "_cycles"},     cycle_count, 0);
        chk({tag, "_done"},       32'(done), 0);
        chk({tag, "_timed_out"},  32'(timed_out), 0);
    endtask

    task automatic chk_beat(input int i, input logic phase);
        chk("beat_valid",  32'(dump_valid), 1);
        chk("beat_data",   dump_data, mem[i]);
        chk("beat_index",  32'(dump_index), 32'(i));
        chk("beat_last",   32'(dump_last), (i == DW - 1) ? 1 : 0);
        chk("beat_phase",  32'(dump_phase), 32'(phase));
        chk("beat_addr",   dmem_addr, BASE + 4 * i);
        chk("beat_memsel", 32'(mem_sel), 1);
        chk("beat_preset", 32'(proc_reset), 1);
    endtask

    // Entered with the controller in its read state for word 0.
    task automatic collect_dump(input logic phase, input int stall_beat, input int stall_len,
                                input bit rnd, input logic [31:0] exp_cyc, input logic exp_to);
        for (int i = 0; i < DW; i++) begin
            int cnt;
            int s;
            cnt = 0;
            chk("rd_valid_low", 32'(dump_valid), 0);
            chk("rd_mem_sel",   32'(mem_sel), 1);
            chk("rd_preset",    32'(proc_reset), 1);
            while (!dump_valid && cnt < 20) begin
                tick();
                cnt++;
            end
            chk("rd_latency", 32'(cnt), 1);
            s = (i == stall_beat) ? stall_len : (rnd ? int'($urandom_range(0, 3)) : 0);
            dump_ready = 1'b0;
            repeat (s) begin
                chk_beat(i, phase);
                tick();
            end
            chk_beat(i, phase);
            dump_ready = 1'b1;
            tick();
            dump_ready = 1'b0;
        end
        if (phase) begin
            chk("end_done",      32'(done), 1);
            chk("end_valid",     32'(dump_valid), 0);
            chk("end_preset",    32'(proc_reset), 1);
            chk("end_mem_sel",   32'(mem_sel), 0);
            chk("end_cycles",    cycle_count, exp_cyc);
            chk("end_timed_out", 32'(timed_out), 32'(exp_to));
        end else begin
            chk("init_to_run_preset", 32'(proc_reset), 0);
            chk("init_to_run_phase",  32'(dump_phase), 1);
            chk("init_to_run_cycles", cycle_count, 0);
        end
    endtask

    // Start, hold, optional initial dump; leaves the bench on the first RUN cycle.
    task automatic start_and_hold(input bit rnd);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_done_clr", 32'(done), 0);
        chk("start_to_clr",   32'(timed_out), 0);
        chk("start_cyc_clr",  cycle_count, 0);
        for (int k = 0; k < RC; k++) begin
            chk("hold_preset",  32'(proc_reset), 1);
            chk("hold_mem_sel", 32'(mem_sel), 0);
            tick();
        end
`ifdef RUN_DUMP_INITIAL_EN
        collect_dump(1'b0, -1, 0, rnd, 0, 1'b0);
`endif
    endtask

    task automatic run_prog(input int halt_at, input int stall_beat, input int stall_len,
                            input bit rnd);
        int r;
        bit fin;
        logic [31:0] exp_cyc;
        logic exp_to;
        start_and_hold(rnd);
        r       = 0;
        fin     = 1'b0;
        exp_cyc = 0;
        exp_to  = 1'b0;
        while (!fin) begin
            inst_from_mem = (r == halt_at) ? HALT : ($urandom & 32'h7FFF_FFFF);
            start = 1'($urandom_range(0, 1));
            chk("run_preset",  32'(proc_reset), 0);
            chk("run_mem_sel", 32'(mem_sel), 0);
            chk("run_cycles",  cycle_count, 32'(r));
            chk("run_valid",   32'(dump_valid), 0);
            if (r == halt_at) begin
                fin     = 1'b1;
                exp_to  = 1'b0;
                exp_cyc = 32'(r);
            end else if (r == MC - 1) begin
                fin     = 1'b1;
                exp_to  = 1'b1;
                exp_cyc = 32'(r);
            end
            tick();
            r++;
        end
        start         = 1'b0;
        inst_from_mem = 32'h0;
        chk("halt_mem_sel",   32'(mem_sel), 1);
        chk("halt_preset",    32'(proc_reset), 1);
        chk("halt_timed_out", 32'(timed_out), 32'(exp_to));
        collect_dump(1'b1, stall_beat, stall_len, rnd, exp_cyc, exp_to);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        inst_from_mem = 32'h0;
        dump_ready    = 1'b0;
        for (int i = 0; i < DW; i++) mem[i] = 32'h0;
        tick();
        tick();
        chk_reset_values("por");
        reset = 1'b0;
        tick();
        chk("idle_preset", 32'(proc_reset), 1);
        chk("idle_done",   32'(done), 0);

        // Directed: words 1,1,2,3, halt at count 10, ready always high.
        mem[0] = 32'd1; mem[1] = 32'd1; mem[2] = 32'd2; mem[3] = 32'd3;
        run_prog(10, -1, 0, 1'b0);

        // Beat 1 stalled for 5 cycles, random contents; restart from DONE.
        for (int i = 0; i < DW; i++) mem[i] = $urandom;
        run_prog(int'($urandom_range(0, 15)), 1, 5, 1'b0);

        // No halt: timeout on the last RUN cycle.
        run_prog(1000, -1, 0, 1'b0);

        // Halt and timeout on the same cycle: halt wins.
        run_prog(MC - 1, -1, 0, 1'b0);

        // Asynchronous reset in the middle of RUN.
        inst_from_mem = 32'h0;
        start_and_hold(1'b0);
        repeat (4) tick();
        chk("pre_reset_run", 32'(proc_reset), 0);
        #3 reset = 1'b1;
        #1;
        chk_reset_values("mid_run");
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < DW; i++) mem[i] = $urandom;
        run_prog(int'($urandom_range(0, 12)), -1, 0, 1'b1);

        // Randomised runs: halt point, contents and back-pressure.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < DW; i++) mem[i] = $urandom;
            run_prog(int'($urandom_range(0, 24)), int'($urandom_range(0, DW - 1)),
                     int'($urandom_range(0, 6)), 1'b1);
        end

        // Asynchronous reset while a beat is being offered.
        start_and_hold(1'b0);
        inst_from_mem = HALT;
        tick();
        inst_from_mem = 32'h0;
        tick();
        chk("pre_reset_dump_valid", 32'(dump_valid), 1);
        #3 reset = 1'b1;
        #1;
        chk_reset_values("mid_dump");
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/run_dump_ctrl.md
# run_dump_ctrl

Synthesizable run controller and memory-dump engine for the multi-cycle processor test harness. It sequences processor reset, runs the core until a halt instruction or a cycle timeout, then freezes the core, takes over the DMEM address bus, and streams a parametrised window of DMEM words out over a valid/ready port. It replaces hand-written reset/halt/dump logic in per-program benches with one reusable block between `processor`, `imem` and `dmem`.

## Interface
- `ADDR_W`, 32, DMEM address width
- `DATA_W`, 32, DMEM word width
- `INSTR_W`, 32, instruction width
- `DUMP_BASE`, 8192, byte address of first dumped word
- `DUMP_WORDS`, 46, number of words dumped; must be ≥1
- `RESET_CYCLES`, 1, cycles `proc_reset` is held after `start`; must be ≥1
- `MAX_CYCLES`, 100000, RUN-cycle timeout
- `HALT_INSTR`, 32'hFFFF_FFFF, instruction word that ends a run
- `clock` in 1: single clock; all state changes on rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: begin run; sampled only in IDLE and DONE
- `inst_from_mem` in INSTR_W: current fetched instruction
- `proc_reset` out 1: reset to processor
- `mem_sel` out 1: 1 = controller owns DMEM address bus (external mux)
- `dmem_addr` out ADDR_W: dump read address
- `dmem_data` in DATA_W: DMEM read data, combinational from `dmem_addr`
- `dump_valid` out 1; `dump_ready` in 1: dump stream handshake
- `dump_data` out DATA_W; `dump_index` out 16; `dump_last` out 1
- `dump_phase` out 1: 0 = initial dump, 1 = final dump
- `cycle_count` out 32: RUN cycles elapsed
- `done` out 1; `timed_out` out 1

## Operation
- States: IDLE, RESET_HOLD, (INIT_DUMP_RD, INIT_DUMP_OUT), RUN, DUMP_RD, DUMP_OUT, DONE.
- Reset values: state IDLE, `proc_reset`=1, `mem_sel`=0, `dmem_addr`=0, `dump_valid`=0, `dump_data`=0, `dump_index`=0, `dump_last`=0, `dump_phase`=1, `cycle_count`=0, `done`=0, `timed_out`=0.
- IDLE/DONE + `start` → RESET_HOLD; clears `cycle_count`, `done`, `timed_out`, word index. `start` ignored in all other states.
- RESET_HOLD: `proc_reset`=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN: `proc_reset`=0, `mem_sel`=0, `cycle_count` +1 per cycle (saturates at 2^32−1). `inst_from_mem`==HALT_INSTR → DUMP_RD. Else `cycle_count`==MAX_CYCLES−1 → `timed_out`=1, DUMP_RD. Both in the same cycle: halt wins, `timed_out`=0.
- DUMP_RD: `proc_reset`=1, `mem_sel`=1, `dmem_addr` = DUMP_BASE + 4·idx (mod 2^ADDR_W). `dmem_data` is captured into `dump_data` at the edge; go to DUMP_OUT.
- DUMP_OUT: `dump_valid`=1, `dump_index`=idx, `dump_last`=(idx==DUMP_WORDS−1). `dump_data`, `dump_index` and `dump_last` are stable while `dump_valid` && !`dump_ready`. On handshake: if last → DONE, else idx+1 → DUMP_RD.
- DONE: `done`=1, `proc_reset`=1, `mem_sel`=0; `cycle_count` and `timed_out` hold.
- Async `reset` in any state, including mid-dump: immediate return to reset values; `dump_valid` drops without handshake.

## Timing
- `start` sampled at edge N → RESET_HOLD from N+1; first RUN cycle at N+1+RESET_CYCLES, with `cycle_count`=0 during that cycle.
- Halt sampled at edge M → `proc_reset`=1 and `mem_sel`=1 from M+1; the core executes no further instructions.
- Each word takes ≥2 cycles (DUMP_RD + DUMP_OUT), even with `dump_ready` held high. Minimum dump is 2·DUMP_WORDS cycles.
- `done` rises on the cycle after the last handshake.

## Configuration
- `RUN_DUMP_INITIAL_EN` defined: after RESET_HOLD, the block performs a full dump with `dump_phase`=0 and `proc_reset` held high (INIT_DUMP_RD/INIT_DUMP_OUT follow the same rules as DUMP_RD/DUMP_OUT), then enters RUN. The final dump uses `dump_phase`=1.
- Not defined: INIT states are absent, RESET_HOLD goes straight to RUN, and `dump_phase` is tied to 1.

## Test plan
- Reset mid-RUN → all outputs return to reset values within the same cycle; `start` afterwards runs normally.
- RESET_CYCLES=3, `start` at edge 5 → `proc_reset` low from edge 9; HALT_INSTR presented at `cycle_count`=10 → `mem_sel`=1 at the next edge; `cycle_count` holds 10 in DONE.
- DUMP_BASE=8192, DUMP_WORDS=4, DMEM words 1,1,2,3, `dump_ready` always 1 → 4 beats with addresses 8192/8196/8200/8204, `dump_last` only on index 3, `done` 8 cycles after halt.
- `dump_ready` low for 5 cycles on beat 1 → `dump_data`/`dump_index` stable; no address advance; beat order preserved.
- MAX_CYCLES=20, no halt → `timed_out`=1, dump starts after `cycle_count`=19; halt and timeout in the same cycle → `timed_out`=0.
- With `RUN_DUMP_INITIAL_EN`: a `dump_phase`=0 dump completes while `proc_reset`=1, then RUN, then a `dump_phase`=1 dump.
